word_pair_fifo: RTL and testbench

- Downstream stage of the 16-to-10 word interface; consumes its two 10-bit output buffers and their per-buffer valid flags (up to two words per cycle).
- Queues words in arrival order: buffer0 word first, then buffer1 word.
- Presents one word per cycle on a valid/ready stream to the next consumer.
- Provides back-pressure, a fill level and a sticky overflow flag.

---
 rtl/word_if_pkg.sv | 9 +
 rtl/word_fifo_mem.sv | 33 +++
 rtl/word_pair_fifo.sv | 87 ++++++++
 tb/tb_word_pair_fifo.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/word_if_pkg.sv
// Shared definitions for the 16-to-10 word interface and its downstream FIFO.
package word_if_pkg;

  localparam int WORD_W        = 10;
  localparam int DEFAULT_DEPTH = 8;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/word_fifo_mem.sv
// Word storage for word_pair_fifo: two write ports at consecutive slots
// (waddr and waddr+1, wrapping) and one asynchronous read port.
module word_fifo_mem #(
  parameter int WORD_W = 10,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic                     we0,
  input  logic [WORD_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [WORD_W-1:0]        wdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WORD_W-1:0]        rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     waddr1;

  // Second slot of a pair wraps naturally because DEPTH is a power of two.
  assign waddr1 = waddr + AW'(1);

  // Storage writes; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr]  <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/word_pair_fifo.sv
// Pair-input, single-word-output FIFO behind the 16-to-10 word interface.
// Accepts up to two words per cycle (buffer0 word first), emits one word per
// cycle on a valid/ready stream, reports its fill level and a sticky overflow.
module word_pair_fifo #(
  parameter  int WORD_W = word_if_pkg::WORD_W,
  parameter  int DEPTH  = word_if_pkg::DEFAULT_DEPTH,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data0,
  input  logic              in_valid0,
  input  logic [WORD_W-1:0] in_data1,
  input  logic              in_valid1,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic              overflow
);

  import word_if_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              ovf;
  logic              any_valid;
  logic              we0;
  logic              we1;
  logic              pop;
  logic [LVL_W-1:0]  npush;
  logic [WORD_W-1:0] wdata0;
  logic [WORD_W-1:0] rd_data;

  // Room for a full pair is judged on the registered count only, so a pop in
  // the same cycle never opens the door early.
  assign in_ready = (count <= LVL_W'(DEPTH - 2));

  // Write/pop decode; a lone buffer1 word takes the first slot so no gap is left.
  always_comb begin
    any_valid = in_valid0 | in_valid1;
    we0       = in_ready & any_valid;
    we1       = in_ready & in_valid0 & in_valid1;
    wdata0    = in_valid0 ? in_data0 : in_data1;
    npush     = we1 ? LVL_W'(2) : (we0 ? LVL_W'(1) : '0);
    out_valid = (count != '0);
    pop       = out_valid & out_ready;
    out_data  = out_valid ? rd_data : '0;
  end

  word_fifo_mem #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk    (clk),
    .waddr  (wr_ptr),
    .we0    (we0),
    .wdata0 (wdata0),
    .we1    (we1),
    .wdata1 (in_data1),
    .raddr  (rd_ptr),
    .rdata  (rd_data)
  );

  // Pointer, occupancy and sticky-overflow state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + npush[AW-1:0];
      rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, pop};
      count  <= count + npush - {{(LVL_W-1){1'b0}}, pop};
      ovf    <= ovf | (any_valid & ~in_ready);
    end
  end

  assign level    = count;
  assign overflow = ovf;

endmodule

// File: tb/tb_word_pair_fifo.sv
// Scoreboard bench for word_pair_fifo: a driver feeds directed and random
// traffic and queues the words the FIFO must accept; a monitor pops the queue
// and compares on every handshake at the output.
module tb_word_pair_fifo;
  import word_if_pkg::*;

  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [9:0]       in_data0 = '0;
  logic             in_valid0 = 1'b0;
  logic [9:0]       in_data1 = '0;
  logic             in_valid1 = 1'b0;
  logic             in_ready;
  logic [9:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [LVL_W-1:0] level;
  logic             overflow;

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];
  int    mcount = 0;
  bit    movf   = 1'b0;

  always #5 clk = ~clk;

  word_pair_fifo #(.WORD_W(10), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data0  (in_data0),
    .in_valid0 (in_valid0),
    .in_data1  (in_data1),
    .in_valid1 (in_valid1),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output word must be the oldest queued word.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("pop_unexpected", 32'(out_valid), 32'(0));
      else                   check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  // One cycle of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit v0, input logic [9:0] d0, input bit v1,
                       input logic [9:0] d1, input bit ordy);
    bit acc;
    in_valid0 = v0; in_data0 = d0; in_valid1 = v1; in_data1 = d1; out_ready = ordy;
    check("level",     32'(level),     32'(mcount));
    check("in_ready",  32'(in_ready),  32'((DEPTH - mcount) >= 2));
    check("overflow",  32'(overflow),  32'(movf));
    check("out_valid", 32'(out_valid), 32'(mcount != 0));
    if (mcount == 0) check("out_data_idle", 32'(out_data), 32'(0));
    acc = ((DEPTH - mcount) >= 2);
    if (acc) begin
      if (v0) exp_q.push_back(d0);
      if (v1) exp_q.push_back(d1);
    end else if (v0 || v1) begin
      movf = 1'b1;
    end
    mcount = mcount + (acc ? (int'(v0) + int'(v1)) : 0) - ((mcount != 0 && ordy) ? 1 : 0);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(1'b0, 10'h0, 1'b0, 10'h0, 1'b1);
  endtask

  task automatic push_pair(input bit ordy);
    cycle(1'b1, 10'($urandom), 1'b1, 10'($urandom), ordy);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic mid_reset();
    in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data",  32'(out_data),  32'(0));
    check("rst_level",     32'(level),     32'(0));
    check("rst_overflow",  32'(overflow),  32'(0));
    check("rst_in_ready",  32'(in_ready),  32'(1));
    exp_q.delete();
    mcount = 0;
    movf   = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    mid_reset();

    // Pair ordering
    cycle(1'b1, 10'h101, 1'b1, 10'h102, 1'b0);
    cycle(1'b1, 10'h103, 1'b1, 10'h104, 1'b0);
    drain(6);

    // Fill to full, then overflow and drain in order
    repeat (4) push_pair(1'b0);
    push_pair(1'b0);
    drain(10);

    // Single and simultaneous push/pop
    repeat (2) push_pair(1'b0);
    cycle(1'b0, 10'h0, 1'b1, 10'h2AA, 1'b1);
    push_pair(1'b1);
    push_pair(1'b0);
    push_pair(1'b1);
    drain(8);

    // Wrap-around: bring wr_ptr to 7 then push a straddling pair
    mid_reset();
    repeat (3) push_pair(1'b0);
    drain(6);
    cycle(1'b1, 10'h0AB, 1'b0, 10'h0, 1'b0);
    drain(1);
    cycle(1'b1, 10'h3F0, 1'b1, 10'h3F1, 1'b0);
    drain(3);

    // Reset mid-stream at level 5 with overflow set
    repeat (4) push_pair(1'b0);
    push_pair(1'b0);
    drain(3);
    mid_reset();
    cycle(1'b1, 10'h155, 1'b0, 10'h0, 1'b0);
    drain(2);

    // Randomized traffic with one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) mid_reset();
      cycle(1'($urandom), 10'($urandom), 1'($urandom), 10'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    drain(DEPTH + 2);
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
